// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types and constants for the memory_core FIFO controller.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } fifo_ctrl_state_t;

    localparam logic [1:0]  MC_MODE_FIFO = 2'h1;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_DEPTH_W  = 16;

endpackage

// File: rtl/fifo_occ_cnt.sv
// fifo_occ_cnt: up/down occupancy counter with synchronous clear and
// full/empty flags relative to a depth input.
// Optional macro FIFO_CTRL_ALMOST_EN exposes the next-cycle count.
module fifo_occ_cnt
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_W = DEF_DEPTH_W
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic               dec,
    input  logic [DEPTH_W-1:0] depth,
    output logic [DEPTH_W-1:0] occupancy,
`ifdef FIFO_CTRL_ALMOST_EN
    output logic [DEPTH_W-1:0] occ_next,
`endif
    output logic               full,
    output logic               empty
);

    logic [DEPTH_W-1:0] r_occ;
    logic [DEPTH_W-1:0] w_occ_next;

    // Next count: clear wins, simultaneous inc/dec cancel
    always_comb begin
        w_occ_next = r_occ;
        if (clr) begin
            w_occ_next = '0;
        end else if (inc && !dec) begin
            w_occ_next = r_occ + 1'b1;
        end else if (dec && !inc) begin
            w_occ_next = r_occ - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    assign occupancy = r_occ;
    assign full      = (r_occ >= depth);
    assign empty     = (r_occ == '0);
`ifdef FIFO_CTRL_ALMOST_EN
    assign occ_next  = w_occ_next;
`endif

endmodule

// File: rtl/fifo_mode_ctrl.sv
// fifo_mode_ctrl: configures a memory_core as a FIFO (flush/config sequence,
// depth latch) and gates producer writes / consumer reads by occupancy.
// Optional macro FIFO_CTRL_ALMOST_EN adds ALMOST_TH, almost_full, almost_empty.
module fifo_mode_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH_W   = DEF_DEPTH_W,
    parameter int unsigned FLUSH_CYC = 2
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    parameter int unsigned ALMOST_TH = 2
`endif
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic               cfg_stop,
    input  logic [DEPTH_W-1:0] cfg_depth,
    output logic               cfg_err,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               host_rdy,
    output logic               out_vld,
    output logic [DATA_W-1:0]  out_data,
    output logic               mc_clk_en,
    output logic               mc_flush,
    output logic [1:0]         mc_mode,
    output logic               mc_circular_en,
    output logic               mc_tile_en,
    output logic [DEPTH_W-1:0] mc_depth,
    output logic               mc_wen,
    output logic               mc_ren,
    output logic [DATA_W-1:0]  mc_data_in,
    input  logic [DATA_W-1:0]  mc_data_out,
    input  logic               mc_valid_out,
    output logic [DEPTH_W-1:0] occupancy,
    output logic               busy
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic               almost_full,
    output logic               almost_empty
`endif
);

    localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    fifo_ctrl_state_t   r_state;
    fifo_ctrl_state_t   w_state_next;
    logic [FC_W-1:0]    r_flush_cnt;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_cfg_err;

    logic               w_start_ok;
    logic               w_full;
    logic               w_empty;
    logic [DEPTH_W-1:0] w_occ;
    logic               w_clr;
    logic               w_in_rdy;
    logic               w_wen;
    logic               w_ren;
    logic               w_flush;
    logic               w_active;
    logic               w_out_vld;

    assign w_start_ok = cfg_start && (r_state == ST_IDLE) && (cfg_depth != '0);
    assign w_clr      = (r_state == ST_FLUSH);

    fifo_occ_cnt #(
        .DEPTH_W (DEPTH_W)
    ) u_occ (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .inc       (w_wen),
        .dec       (w_ren),
        .depth     (r_depth),
        .occupancy (w_occ),
`ifdef FIFO_CTRL_ALMOST_EN
        .occ_next  (w_occ_next),
`endif
        .full      (w_full),
        .empty     (w_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok)          w_state_next = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == '0)   w_state_next = ST_RUN;
            ST_RUN:   if (cfg_stop)            w_state_next = ST_DRAIN;
            // Empty implies no read can be issued this cycle
            ST_DRAIN: if (w_empty)             w_state_next = ST_IDLE;
            default:                           w_state_next = ST_IDLE;
        endcase
    end

    // Per-state outputs; in_rdy depends only on state and occupancy
    always_comb begin
        w_flush   = 1'b0;
        w_active  = 1'b0;
        w_in_rdy  = 1'b0;
        w_wen     = 1'b0;
        w_ren     = 1'b0;
        w_out_vld = 1'b0;
        case (r_state)
            ST_FLUSH: begin
                w_flush  = 1'b1;
                w_active = 1'b1;
            end
            ST_RUN: begin
                w_active  = 1'b1;
                w_in_rdy  = !w_full;
                w_wen     = in_vld && !w_full;
                w_ren     = host_rdy && !w_empty;
                w_out_vld = mc_valid_out;
            end
            ST_DRAIN: begin
                w_active  = 1'b1;
                w_ren     = host_rdy && !w_empty;
                w_out_vld = mc_valid_out;
            end
            default: ;
        endcase
    end

    // Depth latch and flush-length counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth     <= '0;
            r_flush_cnt <= '0;
        end else if (w_start_ok) begin
            r_depth     <= cfg_depth;
            r_flush_cnt <= FC_W'(FLUSH_CYC - 1);
        end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // Rejected-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_start && !w_start_ok;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    logic [DEPTH_W-1:0] w_occ_next;
    logic [DEPTH_W-1:0] w_depth_next;
    logic               r_almost_full;
    logic               r_almost_empty;

    assign w_depth_next = w_start_ok ? cfg_depth : r_depth;

    // Flags registered from next occupancy; threshold add avoids depth-TH underflow
    always_ff @(posedge clk) begin
        if (rst || (w_state_next == ST_IDLE)) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b0;
        end else begin
            r_almost_full  <= ({1'b0, w_occ_next} + (DEPTH_W+1)'(ALMOST_TH)) >= {1'b0, w_depth_next};
            r_almost_empty <= {1'b0, w_occ_next} <= (DEPTH_W+1)'(ALMOST_TH);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    assign cfg_err        = r_cfg_err;
    assign in_rdy         = w_in_rdy;
    assign out_vld        = w_out_vld;
    assign out_data       = mc_data_out;
    assign mc_clk_en      = w_active;
    assign mc_flush       = w_flush;
    assign mc_mode        = MC_MODE_FIFO;
    assign mc_circular_en = 1'b1;
    assign mc_tile_en     = w_active;
    assign mc_depth       = r_depth;
    assign mc_wen         = w_wen;
    assign mc_ren         = w_ren;
    assign mc_data_in     = in_data;
    assign occupancy      = w_occ;
    assign busy           = w_active;

endmodule

// File: tb/tb_fifo_mode_ctrl.sv
// tb_fifo_mode_ctrl: directed vector table, hand sequences and random traffic
// for fifo_mode_ctrl against a behavioural reference model and a core model.
module tb_fifo_mode_ctrl;

    localparam int FLUSH_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_stop;
    logic [15:0] cfg_depth;
    logic        cfg_err;
    logic        in_vld, in_rdy;
    logic [15:0] in_data;
    logic        host_rdy, out_vld;
    logic [15:0] out_data;
    logic        mc_clk_en, mc_flush, mc_circular_en, mc_tile_en;
    logic [1:0]  mc_mode;
    logic [15:0] mc_depth;
    logic        mc_wen, mc_ren;
    logic [15:0] mc_data_in;
    logic [15:0] mc_data_out;
    logic        mc_valid_out;
    logic [15:0] occupancy;
    logic        busy;
`ifdef FIFO_CTRL_ALMOST_EN
    logic        almost_full, almost_empty;
`endif

    fifo_mode_ctrl #(.DATA_W(16), .DEPTH_W(16), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_depth(cfg_depth), .cfg_err(cfg_err), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_data(in_data), .host_rdy(host_rdy), .out_vld(out_vld), .out_data(out_data),
        .mc_clk_en(mc_clk_en), .mc_flush(mc_flush), .mc_mode(mc_mode),
        .mc_circular_en(mc_circular_en), .mc_tile_en(mc_tile_en), .mc_depth(mc_depth),
        .mc_wen(mc_wen), .mc_ren(mc_ren), .mc_data_in(mc_data_in),
        .mc_data_out(mc_data_out), .mc_valid_out(mc_valid_out),
        .occupancy(occupancy), .busy(busy)
`ifdef FIFO_CTRL_ALMOST_EN
        , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
    );

    always #5 clk = ~clk;

    // memory_core stand-in: one-cycle read latency FIFO storage
    logic [15:0] core_mem[$];
    always @(posedge clk) begin
        if (rst || mc_flush) begin
            core_mem.delete();
            mc_valid_out <= 1'b0;
        end else begin
            if (mc_ren && core_mem.size() > 0) begin
                mc_valid_out <= 1'b1;
                mc_data_out  <= core_mem.pop_front();
            end else begin
                mc_valid_out <= 1'b0;
            end
            if (mc_wen) core_mem.push_back(mc_data_in);
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference model: mode 0 idle, 1 flushing, 2 running, 3 draining
    int          m_mode, m_fl_left, m_occ, m_depth;
    bit          m_err, m_pv;
    logic [15:0] m_pd;
    logic [15:0] m_q[$];
    bit          e_rdy, e_wen, e_ren;

    task automatic model_reset();
        m_mode = 0; m_fl_left = 0; m_occ = 0; m_depth = 0;
        m_err = 0; m_pv = 0; m_pd = '0;
        m_q.delete();
    endtask

    task automatic check_model();
        e_rdy = (m_mode == 2) && (m_occ < m_depth);
        e_wen = e_rdy && in_vld;
        e_ren = (m_mode >= 2) && host_rdy && (m_occ > 0);
        chk("busy",      32'(busy),       32'(m_mode != 0));
        chk("clk_en",    32'(mc_clk_en),  32'(m_mode != 0));
        chk("tile_en",   32'(mc_tile_en), 32'(m_mode != 0));
        chk("flush",     32'(mc_flush),   32'(m_mode == 1));
        chk("in_rdy",    32'(in_rdy),     32'(e_rdy));
        chk("wen",       32'(mc_wen),     32'(e_wen));
        chk("ren",       32'(mc_ren),     32'(e_ren));
        chk("occupancy", 32'(occupancy),  m_occ);
        chk("mc_depth",  32'(mc_depth),   m_depth);
        chk("cfg_err",   32'(cfg_err),    32'(m_err));
        chk("mc_mode",   32'(mc_mode),    32'h1);
        chk("circular",  32'(mc_circular_en), 32'h1);
        chk("out_vld",   32'(out_vld),    32'(m_pv && m_mode >= 2));
        if (m_pv && m_mode >= 2) chk("out_data", 32'(out_data), 32'(m_pd));
        if (e_wen) chk("data_in", 32'(mc_data_in), 32'(in_data));
    endtask

    task automatic update_model();
        int occ_new;
        if (rst) begin
            model_reset();
            return;
        end
        m_err = cfg_start && (m_mode != 0 || cfg_depth == 0);
        m_pv = 1'b0;
        if (e_ren && m_q.size() > 0) begin
            m_pv = 1'b1;
            m_pd = m_q.pop_front();
        end
        if (e_wen) m_q.push_back(in_data);
        occ_new = (m_mode == 1) ? 0 : m_occ + int'(e_wen) - int'(e_ren);
        case (m_mode)
            0: if (cfg_start && cfg_depth != 0) begin
                   m_mode = 1; m_fl_left = FLUSH_CYC; m_depth = int'(cfg_depth); m_q.delete();
               end
            1: begin
                   m_fl_left--;
                   if (m_fl_left == 0) m_mode = 2;
               end
            2: if (cfg_stop) m_mode = 3;
            3: if (m_occ == 0) m_mode = 0;
            default: m_mode = 0;
        endcase
        m_occ = occ_new;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic set_in(input bit st, input bit sp, input logic [15:0] dep,
                          input bit vld, input logic [15:0] dat, input bit hr);
        cfg_start = st; cfg_stop = sp; cfg_depth = dep;
        in_vld = vld; in_data = dat; host_rdy = hr;
    endtask

    typedef struct {
        bit st; bit sp; logic [15:0] dep; bit vld; logic [15:0] dat; bit hr;
        bit x_rdy; bit x_wen; bit x_ren; bit x_flush; bit x_err; bit x_busy;
        int x_occ; int x_depth;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // inputs                                 | rdy wen ren fl err busy occ dep
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,0,0,0, 0,0});
        tbl.push_back('{1,0,16'd4,0,16'h00,0,      0,0,0,0,0,0, 0,0});
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,1,0,1, 0,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,1,0,1, 0,4});
        tbl.push_back('{0,0,16'd0,1,16'h11,0,      1,1,0,0,0,1, 0,4});
        tbl.push_back('{0,0,16'd0,1,16'h12,0,      1,1,0,0,0,1, 1,4});
        tbl.push_back('{0,0,16'd0,1,16'h13,0,      1,1,0,0,0,1, 2,4});
        tbl.push_back('{0,0,16'd0,1,16'h14,0,      1,1,0,0,0,1, 3,4});
        tbl.push_back('{0,0,16'd0,1,16'h15,0,      0,0,0,0,0,1, 4,4});
        tbl.push_back('{0,0,16'd0,1,16'h15,1,      0,0,1,0,0,1, 4,4});
        tbl.push_back('{0,0,16'd0,1,16'h15,0,      1,1,0,0,0,1, 3,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,0,0,1, 4,4});
        tbl.push_back('{1,0,16'd7,0,16'h00,0,      0,0,0,0,0,1, 4,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,0,1,1, 4,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,0,0,1, 4,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,1,      0,0,1,0,0,1, 4,4});
        tbl.push_back('{0,1,16'd0,0,16'h00,0,      1,0,0,0,0,1, 3,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,1,      0,0,1,0,0,1, 3,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,1,      0,0,1,0,0,1, 2,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,1,      0,0,1,0,0,1, 1,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,1,      0,0,0,0,0,1, 0,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,1,      0,0,0,0,0,0, 0,4});
        tbl.push_back('{1,0,16'd0,0,16'h00,0,      0,0,0,0,0,0, 0,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,0,1,0, 0,4});
        tbl.push_back('{0,0,16'd0,0,16'h00,0,      0,0,0,0,0,0, 0,4});

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        model_reset();
        #1 rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].st, tbl[i].sp, tbl[i].dep, tbl[i].vld, tbl[i].dat, tbl[i].hr);
            @(negedge clk);
            check_model();
            chk($sformatf("t%0d_in_rdy", i), 32'(in_rdy),   32'(tbl[i].x_rdy));
            chk($sformatf("t%0d_wen", i),    32'(mc_wen),   32'(tbl[i].x_wen));
            chk($sformatf("t%0d_ren", i),    32'(mc_ren),   32'(tbl[i].x_ren));
            chk($sformatf("t%0d_flush", i),  32'(mc_flush), 32'(tbl[i].x_flush));
            chk($sformatf("t%0d_err", i),    32'(cfg_err),  32'(tbl[i].x_err));
            chk($sformatf("t%0d_busy", i),   32'(busy),     32'(tbl[i].x_busy));
            chk($sformatf("t%0d_occ", i),    32'(occupancy), tbl[i].x_occ);
            chk($sformatf("t%0d_depth", i),  32'(mc_depth), tbl[i].x_depth);
            @(posedge clk);
            update_model();
            #1;
        end

        // Empty read gating, then simultaneous write+read at occupancy 2
        set_in(1, 0, 4, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step(); step();
        set_in(0, 0, 0, 0, 0, 1); #1 chk("empty_no_ren", 32'(mc_ren), 32'h0); step();
        set_in(0, 0, 0, 1, 16'h21, 0); step();
        set_in(0, 0, 0, 1, 16'h22, 0); step();
        set_in(0, 0, 0, 1, 16'h23, 1);
        #1 chk("rw_wen", 32'(mc_wen), 32'h1);
        chk("rw_ren", 32'(mc_ren), 32'h1);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        #1 chk("rw_occ_hold", 32'(occupancy), 32'h2);
        set_in(0, 1, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 10 && busy; k++) step();
        chk("drain_idle_busy", 32'(busy), 32'h0);
        chk("drain_idle_clk_en", 32'(mc_clk_en), 32'h0);

        // Reset in the middle of RUN
        set_in(1, 0, 3, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step(); step();
        set_in(0, 0, 0, 1, 16'h31, 0); step();
        set_in(0, 0, 0, 1, 16'h32, 0); step();
        rst = 1'b1; set_in(0, 0, 0, 0, 0, 0); step();
        rst = 1'b0; set_in(0, 0, 0, 1, 16'h33, 1);
        #1;
        chk("rst_busy",   32'(busy),       32'h0);
        chk("rst_in_rdy", 32'(in_rdy),     32'h0);
        chk("rst_wen",    32'(mc_wen),     32'h0);
        chk("rst_ren",    32'(mc_ren),     32'h0);
        chk("rst_flush",  32'(mc_flush),   32'h0);
        chk("rst_clk_en", 32'(mc_clk_en),  32'h0);
        chk("rst_tile",   32'(mc_tile_en), 32'h0);
        chk("rst_occ",    32'(occupancy),  32'h0);
        chk("rst_depth",  32'(mc_depth),   32'h0);
        chk("rst_err",    32'(cfg_err),    32'h0);
        step();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
                   16'($urandom_range(0, 5)), $urandom_range(0, 2) != 0,
                   16'($urandom), 1'($urandom_range(0, 1)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
